adder_sub_arbiter: RTL and testbench

- Shares one 16-bit signed `adder_sub` datapath between NUM_REQ requesters.
- Arbitrates requests round-robin, drives the shared unit's operand and mode inputs, and captures its result and flags.
- Returns each result on a single valid/ready response channel, tagged with the requester id.
- Sits between the requesting blocks and the single `adder_sub` instance; the instance is external and wired to the `as_*` ports.

---
 rtl/adder_sub_arbiter.sv | 135 +++++++++++++
 tb/tb_adder_sub_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_sub_arbiter.sv
// Round-robin arbiter sharing one external adder_sub datapath between NUM_REQ requesters.
// Optional build macro ADDSUB_SATURATE_EN clamps captured results on signed overflow.
module adder_sub_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_op1,
    input  logic [NUM_REQ*WIDTH-1:0] req_op2,
    input  logic [NUM_REQ-1:0]       req_sub,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_result,
    output logic                     rsp_over,
    output logic                     rsp_carry,
    output logic [WIDTH-1:0]         as_op1,
    output logic [WIDTH-1:0]         as_op2,
    output logic                     as_Op,
    input  logic [WIDTH-1:0]         as_Out,
    input  logic                     as_over,
    input  logic                     as_carry
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   last_grant_q;
    logic [ID_W-1:0]   grant;
    logic [ID_W-1:0]   cand;
    logic              grant_found;
    int unsigned       scan_idx;
    logic [WIDTH-1:0]  sel_op1, sel_op2;
    logic              sel_sub;
    logic [WIDTH-1:0]  capture_result;

    // Scan starts one past the last grant so every requester gets a turn.
    always_comb begin
        grant       = '0;
        cand        = '0;
        grant_found = 1'b0;
        scan_idx    = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            scan_idx = (32'(last_grant_q) + k) % NUM_REQ;
            cand     = ID_W'(scan_idx);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant       = cand;
            end
        end
    end

    always_comb begin
        sel_op1 = '0;
        sel_op2 = '0;
        sel_sub = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant) begin
                sel_op1 = req_op1[i*WIDTH +: WIDTH];
                sel_op2 = req_op2[i*WIDTH +: WIDTH];
                sel_sub = req_sub[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    req_ready[grant] = 1'b1;
                    state_d          = StExec;
                end
            end
            StExec: state_d = StResp;
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        capture_result = as_Out;
`ifdef ADDSUB_SATURATE_EN
        // A wrapped-positive sum means the true result was below the negative limit.
        if (as_over) begin
            capture_result = as_Out[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                             : {1'b1, {(WIDTH-1){1'b0}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            as_op1       <= '0;
            as_op2       <= '0;
            as_Op        <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_result   <= '0;
            rsp_over     <= 1'b0;
            rsp_carry    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && grant_found) begin
                as_op1       <= sel_op1;
                as_op2       <= sel_op2;
                as_Op        <= sel_sub;
                last_grant_q <= grant;
            end
            // last_grant_q doubles as the id of the in-flight transaction.
            if (state_q == StExec) begin
                rsp_result <= capture_result;
                rsp_over   <= as_over;
                rsp_carry  <= as_carry;
                rsp_id     <= last_grant_q;
                rsp_valid  <= 1'b1;
            end
            if (state_q == StResp && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adder_sub_arbiter.sv
// Self-checking bench for adder_sub_arbiter: table vectors, reset corner cases, round-robin order
// and randomized traffic against an arithmetic reference model.
module tb_adder_sub_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned WIDTH   = 16;
    localparam int unsigned ID_W    = $clog2(NUM_REQ);

    logic                     clk;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_op1;
    logic [NUM_REQ*WIDTH-1:0] req_op2;
    logic [NUM_REQ-1:0]       req_sub;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_result;
    logic                     rsp_over;
    logic                     rsp_carry;
    logic [WIDTH-1:0]         as_op1;
    logic [WIDTH-1:0]         as_op2;
    logic                     as_Op;
    logic [WIDTH-1:0]         as_Out;
    logic                     as_over;
    logic                     as_carry;

    adder_sub_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_sub    (req_sub),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_over   (rsp_over),
        .rsp_carry  (rsp_carry),
        .as_op1     (as_op1),
        .as_op2     (as_op2),
        .as_Op      (as_Op),
        .as_Out     (as_Out),
        .as_over    (as_over),
        .as_carry   (as_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the external combinational adder_sub unit.
    logic [WIDTH-1:0] mock_b;
    logic [WIDTH:0]   mock_s;
    always_comb begin
        mock_b   = as_Op ? (~as_op2 + 16'd1) : as_op2;
        mock_s   = {1'b0, as_op1} + {1'b0, mock_b};
        as_Out   = mock_s[WIDTH-1:0];
        as_carry = mock_s[WIDTH];
        if (as_Op) as_over = (as_op1[WIDTH-1] != as_op2[WIDTH-1]) && (mock_s[WIDTH-1] != as_op1[WIDTH-1]);
        else       as_over = (as_op1[WIDTH-1] == as_op2[WIDTH-1]) && (mock_s[WIDTH-1] != as_op1[WIDTH-1]);
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: true signed result from integer arithmetic, then wrap / clamp.
    function automatic void ref_calc(input logic [WIDTH-1:0] op1, input logic [WIDTH-1:0] op2,
                                     input logic sub, output logic [WIDTH-1:0] res,
                                     output logic ov, output logic cy);
        int a, b, t, ua, ub;
        a  = $signed(op1);
        b  = $signed(op2);
        t  = sub ? a - b : a + b;
        res = t[WIDTH-1:0];
        ov = (t > 32767) || (t < -32768);
        ua = 32'(op1);
        ub = sub ? ((65536 - 32'(op2)) % 65536) : 32'(op2);
        cy = (ua + ub) >= 65536;
`ifdef ADDSUB_SATURATE_EN
        if (ov) res = (t < 0) ? 16'h8000 : 16'h7FFF;
`endif
    endfunction

    logic             pend  [NUM_REQ];
    logic [WIDTH-1:0] p_op1 [NUM_REQ];
    logic [WIDTH-1:0] p_op2 [NUM_REQ];
    logic             p_sub [NUM_REQ];
    int               model_last;

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]              = pend[i];
            req_op1[i*WIDTH +: WIDTH] = p_op1[i];
            req_op2[i*WIDTH +: WIDTH] = p_op2[i];
            req_sub[i]                = p_sub[i];
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_op();
        case ($urandom_range(0, 7))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'h0000;
            3: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic new_req(input int i);
        pend[i]  = 1'b1;
        p_op1[i] = rand_op();
        p_op2[i] = rand_op();
        p_sub[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_rsp_id"}, 32'(rsp_id), 0);
        check({tag, "_rsp_result"}, 32'(rsp_result), 0);
        check({tag, "_rsp_over"}, 32'(rsp_over), 0);
        check({tag, "_rsp_carry"}, 32'(rsp_carry), 0);
        check({tag, "_as_op1"}, 32'(as_op1), 0);
        check({tag, "_as_op2"}, 32'(as_op2), 0);
        check({tag, "_as_Op"}, 32'(as_Op), 0);
    endtask

    // One model-driven transaction starting in IDLE (time = posedge + 1).
    task automatic txn(input int stall);
        int g;
        int idx;
        logic [NUM_REQ-1:0] exp_rdy;
        logic [WIDTH-1:0] er;
        logic eo, ec;
        drive();
        rsp_ready = 1'b0;
        g = -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (model_last + k) % NUM_REQ;
            if (g < 0 && pend[idx]) g = idx;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        #1;
        check("grant", 32'(req_ready), 32'(exp_rdy));
        @(posedge clk); #1;
        if (g >= 0) begin
            pend[g]    = 1'b0;
            model_last = g;
            drive();
            ref_calc(p_op1[g], p_op2[g], p_sub[g], er, eo, ec);
            check("exec_ready", 32'(req_ready), 0);
            check("exec_valid", 32'(rsp_valid), 0);
            check("as_op1", 32'(as_op1), 32'(p_op1[g]));
            check("as_op2", 32'(as_op2), 32'(p_op2[g]));
            check("as_Op", 32'(as_Op), 32'(p_sub[g]));
            @(posedge clk); #1;
            for (int s = 0; s <= stall; s++) begin
                check("rsp_valid", 32'(rsp_valid), 1);
                check("rsp_id", 32'(rsp_id), 32'(g));
                check("rsp_result", 32'(rsp_result), 32'(er));
                check("rsp_over", 32'(rsp_over), 32'(eo));
                check("rsp_carry", 32'(rsp_carry), 32'(ec));
                check("resp_ready", 32'(req_ready), 0);
                if (s < stall) begin
                    @(posedge clk); #1;
                end
            end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            check("rsp_clear", 32'(rsp_valid), 0);
            check("rsp_hold", 32'(rsp_result), 32'(er));
        end
    endtask

    typedef struct {
        int               id;
        logic [WIDTH-1:0] op1;
        logic [WIDTH-1:0] op2;
        logic             sub;
        logic [WIDTH-1:0] res;
        logic             ov;
        logic             cy;
    } vec_t;

    vec_t tbl[7];
    int   rr_seq[6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 16'd2000, 16'd1000, 1'b0, 16'd3000, 1'b0, 1'b0};
        tbl[1] = '{1, 16'd2000, 16'hFC18, 1'b1, 16'd3000, 1'b0, 1'b0};
        tbl[2] = '{2, 16'hF830, 16'hFC18, 1'b0, 16'hF448, 1'b0, 1'b1};
        tbl[3] = '{2, 16'hF830, 16'hFC18, 1'b1, 16'hFC18, 1'b0, 1'b0};
`ifdef ADDSUB_SATURATE_EN
        tbl[4] = '{3, 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b0};
        tbl[5] = '{0, 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1};
`else
        tbl[4] = '{3, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1, 1'b0};
        tbl[5] = '{0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
`endif
        tbl[6] = '{1, 16'd5, 16'd5, 1'b1, 16'd0, 1'b0, 1'b1};
        rr_seq = '{0, 1, 2, 3, 0, 1};

        for (int i = 0; i < NUM_REQ; i++) begin
            pend[i] = 1'b0; p_op1[i] = '0; p_op2[i] = '0; p_sub[i] = 1'b0;
        end
        rst_n = 1'b0; rsp_ready = 1'b0;
        drive();
        model_last = NUM_REQ - 1;
        repeat (2) @(posedge clk);
        #1;
        check_reset("por");
        rst_n = 1'b1;

        // Table vectors, one requester at a time.
        foreach (tbl[v]) begin
            for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
            pend[tbl[v].id] = 1'b1;
            p_op1[tbl[v].id] = tbl[v].op1;
            p_op2[tbl[v].id] = tbl[v].op2;
            p_sub[tbl[v].id] = tbl[v].sub;
            drive();
            rsp_ready = 1'b1;
            #1;
            check("tbl_ready", 32'(req_ready), 32'(1) << tbl[v].id);
            @(posedge clk); #1;
            pend[tbl[v].id] = 1'b0;
            drive();
            check("tbl_latency", 32'(rsp_valid), 0);
            @(posedge clk); #1;
            check("tbl_valid", 32'(rsp_valid), 1);
            check("tbl_id", 32'(rsp_id), 32'(tbl[v].id));
            check("tbl_result", 32'(rsp_result), 32'(tbl[v].res));
            check("tbl_over", 32'(rsp_over), 32'(tbl[v].ov));
            check("tbl_carry", 32'(rsp_carry), 32'(tbl[v].cy));
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            check("tbl_clear", 32'(rsp_valid), 0);
            model_last = tbl[v].id;
        end

        // Round robin with every requester busy; one long stall in RESP.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_last = NUM_REQ - 1;
        for (int i = 0; i < NUM_REQ; i++) new_req(i);
        for (int r = 0; r < 6; r++) begin
            txn((r == 4) ? 5 : 0);
            check("rr_seq", 32'(rsp_id), 32'(rr_seq[r]));
            new_req(model_last);
        end

        // Reset during EXEC: no response, pointer back to requester 0.
        for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
        new_req(0);
        drive();
        #1;
        check("rstx_ready", 32'(req_ready), 1);
        @(posedge clk); #1;
        pend[0] = 1'b0;
        drive();
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset("rst_exec");
        rst_n = 1'b1;
        model_last = NUM_REQ - 1;
        @(posedge clk); #1;
        check("rst_exec_norsp", 32'(rsp_valid), 0);
        new_req(0);
        new_req(1);
        txn(0);
        check("rst_exec_next", 32'(rsp_id), 0);

        // Reset during RESP after granting requester 1.
        drive();
        #1;
        check("rstr_ready", 32'(req_ready), 2);
        @(posedge clk); #1;
        pend[1] = 1'b0;
        drive();
        @(posedge clk); #1;
        check("rstr_inresp", 32'(rsp_valid), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset("rst_resp");
        rst_n = 1'b1;
        model_last = NUM_REQ - 1;
        new_req(1);
        new_req(2);
        txn(0);
        check("rst_resp_next", 32'(rsp_id), 1);

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!pend[i] && $urandom_range(0, 1) == 1) new_req(i);
                end
            end
            txn(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
